// File: rtl/comp_pkg.sv
// Shared encodings for the sequential magnitude comparator.
package comp_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Result encoding, bit order {y1, y2, y3} = {lt, eq, gt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // Map a single chunk compare onto the result encoding
  function automatic logic [2:0] res_enc(input logic lt, input logic gt);
    if (lt) begin
      return RES_LT;
    end else if (gt) begin
      return RES_GT;
    end
    return RES_EQ;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module comp_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (ca < cb);
  assign eq = (ca == cb);
  assign gt = (ca > cb);

endmodule

// File: rtl/comp_seq.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per cycle, with
// start/busy/done handshake and unsigned or two's-complement modes.
// Optional build macro COMP_SEQ_EARLY_EXIT_EN: leave RUN at the first unequal
// chunk instead of always spending NCHUNK cycles (constant-time by default).
module comp_seq
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             y1,
  output logic             y2,
  output logic             y3
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic [2:0]       r_res;
  logic [2:0]       r_y;

  logic [CHUNK-1:0] w_msk;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  logic             w_last;
  logic             w_finish;
  logic             w_accept;
  logic [2:0]       w_res_acc;

  // Sign-bit flip applies only to the MSB chunk of a signed compare
  always_comb begin
    w_msk          = '0;
    w_msk[CHUNK-1] = r_signed && (r_cnt == '0);
  end

  assign w_ca = r_a[WIDTH-1 -: CHUNK] ^ w_msk;
  assign w_cb = r_b[WIDTH-1 -: CHUNK] ^ w_msk;

  comp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .ca (w_ca),
    .cb (w_cb),
    .lt (w_lt),
    .eq (w_eq),
    .gt (w_gt)
  );

  // First unequal chunk wins; later chunks cannot overwrite it
  assign w_res_acc = r_decided ? r_res : res_enc(w_lt, w_gt);
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_accept  = start && ((r_state == StIdle) || (r_state == StDone));

`ifdef COMP_SEQ_EARLY_EXIT_EN
  assign w_finish = w_last || !w_eq;
`else
  assign w_finish = w_last;
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_finish) w_state_next = StDone;
      StDone:  w_state_next = start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, chunk shifting, sticky result and output latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_res     <= RES_NONE;
      r_y       <= RES_NONE;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_signed  <= signed_mode;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_res     <= RES_NONE;
    end else if (r_state == StRun) begin
      r_a       <= r_a << CHUNK;
      r_b       <= r_b << CHUNK;
      r_cnt     <= r_cnt + 1'b1;
      r_decided <= r_decided || !w_eq;
      r_res     <= w_res_acc;
      if (w_finish) begin
        r_y <= w_res_acc;
      end
    end
  end

  assign busy         = (r_state == StRun);
  assign done         = (r_state == StDone);
  assign {y1, y2, y3} = r_y;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq (WIDTH=8, CHUNK=2): directed vectors plus a
// cycle-level reference model compared against the outputs on every cycle.
module tb_comp_seq;

`ifdef COMP_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       y1;
  logic       y2;
  logic       y3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  comp_seq #(
    .WIDTH (8),
    .CHUNK (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3)
  );

  always #5 clk = ~clk;

  // Expected {lt, eq, gt} straight from integer comparison
  function automatic logic [2:0] exp_res(input logic [7:0] xa, input logic [7:0] xb,
                                         input logic s);
    if (s) begin
      if ($signed(xa) < $signed(xb)) return 3'b100;
      if ($signed(xa) > $signed(xb)) return 3'b001;
    end else begin
      if (xa < xb) return 3'b100;
      if (xa > xb) return 3'b001;
    end
    return 3'b010;
  endfunction

  // Expected cycles in RUN: fixed 4, or index of first differing 2-bit slice + 1
  function automatic int exp_lat(input logic [7:0] xa, input logic [7:0] xb);
    if (EE) begin
      for (int k = 0; k < 4; k++) begin
        if (xa[7-2*k -: 2] != xb[7-2*k -: 2]) return k + 1;
      end
    end
    return 4;
  endfunction

  // Reference model: remaining busy cycles, pending result, visible outputs
  int         m_rem = 0;
  logic       m_done = 1'b0;
  logic [2:0] m_y = 3'b000;
  logic [2:0] m_pend = 3'b000;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem   <= 0;
      m_done  <= 1'b0;
      m_y     <= 3'b000;
      m_valid <= 1'b1;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_y    <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_rem  <= exp_lat(a, b);
        m_pend <= exp_res(a, b, signed_mode);
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      n_tests++;
      if ({busy, done, y1, y2, y3} !== {(m_rem > 0), m_done, m_y}) begin
        n_fail++;
        $display("FAIL model_cycle @%0t: got busy/done/y=%b%b%b%b%b expected %b%b%b", $time,
                 busy, done, y1, y2, y3, (m_rem > 0), m_done, m_y);
      end
      if (done === 1'b1) n_done++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for done from the negedge right after the accepting edge; returns edge count
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_cmp(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic [2:0] ey, input int elat, input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb; signed_mode = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_y"}, {y1, y2, y3}, ey);
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, y1, y2, y3}, 5'b00000);
    rst = 1'b0;

    // Pin the model against hand-computed values
    chk("model_signed_80_7f", exp_res(8'h80, 8'h7F, 1'b1), 3'b100);
    chk("model_unsigned_80_7f", exp_res(8'h80, 8'h7F, 1'b0), 3'b001);
    chk("model_lat_10_20", exp_lat(8'h10, 8'h20), EE ? 2 : 4);

    do_cmp(8'h5A, 8'h5A, 1'b0, 3'b010, 4, "eq_5a");
    do_cmp(8'h80, 8'h7F, 1'b0, 3'b001, EE ? 1 : 4, "u_80_7f");
    do_cmp(8'h80, 8'h7F, 1'b1, 3'b100, EE ? 1 : 4, "s_80_7f");
    do_cmp(8'hFF, 8'hFE, 1'b1, 3'b001, 4, "s_ff_fe");
    do_cmp(8'h33, 8'h31, 1'b1, 3'b001, 4, "s_33_31");

    // Start pulsed during RUN must be ignored
    @(negedge clk);
    a = 8'h01; b = 8'h02; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_start_lat", n, 4);
    chk("ignore_start_y", {y1, y2, y3}, 3'b100);

    // Reset two cycles into RUN discards the compare
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset", {busy, done, y1, y2, y3}, 5'b00000);
    d0 = n_done;
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", n_done - d0, 0);

    // Back-to-back: start held through DONE re-enters RUN directly
    d0 = n_done;
    a = 8'h33; b = 8'h31; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    wait_done(n);
    chk("b2b_first_lat", n, 4);
    chk("b2b_first_y", {y1, y2, y3}, 3'b001);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_rerun_busy", {busy, done}, 2'b10);
    wait_done(n);
    chk("b2b_second_lat", n, EE ? 2 : 4);
    chk("b2b_second_y", {y1, y2, y3}, 3'b100);
    @(negedge clk);
    chk("b2b_done_pulses", n_done - d0, 2);
    chk("b2b_back_idle", {busy, done}, 2'b00);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
